// File: rtl/alu_result_stage.sv
// ALU result output stage: captures the selected result, derives zero/parity
// flags, and presents them through a two-entry skid buffer with a transfer counter.
module alu_result_stage #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_zero,
    output logic                 out_parity,
    output logic [CNT_WIDTH-1:0] xfer_count
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             zero;
        logic             parity;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    entry_t               m_q;
    entry_t               m_nxt;
    entry_t               s_q;
    entry_t               s_nxt;
    entry_t               in_entry;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 acc;
    logic                 take;

    // Readiness depends only on registered state, plus the reset override.
    assign in_ready  = (state != TWO) & ~rst;
    assign out_valid = (state != EMPTY);
    assign acc       = in_valid & in_ready;
    assign take      = out_valid & out_ready;

    // Flags are derived once, at capture time, and travel with the data.
    always_comb begin
        in_entry        = '0;
        in_entry.data   = in_data;
        in_entry.zero   = ~|in_data;
        in_entry.parity = ^in_data;
    end

    // Next-state and storage steering.
    always_comb begin
        state_nxt = state;
        m_nxt     = m_q;
        s_nxt     = s_q;
        cnt_nxt   = cnt_q;

        if (take) begin
            cnt_nxt = cnt_q + CNT_WIDTH'(1);
        end

        unique case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt = ONE;
                    m_nxt     = in_entry;
                end
            end
            ONE: begin
                if (acc && take) begin
                    m_nxt = in_entry;
                end else if (acc) begin
                    state_nxt = TWO;
                    s_nxt     = in_entry;
                end else if (take) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (take) begin
                    state_nxt = ONE;
                    m_nxt     = s_q;
                end
            end
            default: begin
                state_nxt = EMPTY;
            end
        endcase
    end

    // State and storage registers; reset discards both entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            m_q   <= '0;
            s_q   <= '0;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            m_q   <= m_nxt;
            s_q   <= s_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    assign out_data   = m_q.data;
    assign out_zero   = m_q.zero;
    assign out_parity = m_q.parity;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed vector table, hand-written
// corner sequences, and a randomized FIFO scoreboard run.
module tb_alu_result_stage;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic          out_parity;
    logic [CW-1:0] xfer_count;

    alu_result_stage #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .xfer_count (xfer_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [W-1:0]  d;
        logic          ordy;
        logic          ev;
        logic [W-1:0]  ed;
        logic          ez;
        logic          ep;
        logic          eir;
        logic [CW-1:0] ec;
    } vec_t;

    vec_t vecs[11];

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]  mq[$];
    logic [CW-1:0] mcount;
    int            takes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle against the FIFO reference model, then compare all outputs.
    task automatic step(input logic iv, input logic [W-1:0] d, input logic ordy);
        logic m_acc;
        logic m_take;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        m_acc  = iv && (mq.size() < 2);
        m_take = (mq.size() > 0) && ordy;
        @(posedge clk);
        #1;
        if (m_take) begin
            void'(mq.pop_front());
            mcount = mcount + CW'(1);
            takes++;
        end
        if (m_acc) mq.push_back(d);
        chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("xfer_count", 32'(xfer_count), 32'(mcount));
        if (mq.size() > 0) begin
            chk("out_data", 32'(out_data), 32'(mq[0]));
            chk("out_zero", 32'(out_zero), 32'(mq[0] == '0));
            chk("out_parity", 32'(out_parity), 32'(^mq[0]));
        end
    endtask

    task automatic do_reset(input int n);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        mcount = '0;
        takes  = 0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        mcount    = '0;
        takes     = 0;

        // Streaming 00, FF, 01, 80 with out_ready high.
        vecs[0]  = '{1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 4'd0};
        vecs[1]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 4'd1};
        vecs[2]  = '{1'b1, 8'h01, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 4'd2};
        vecs[3]  = '{1'b1, 8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 4'd3};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd4};
        // Stall: 11, 22 accepted, 33 held until the consumer resumes.
        vecs[5]  = '{1'b1, 8'h11, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 4'd4};
        vecs[6]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 4'd4};
        vecs[7]  = '{1'b1, 8'h33, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 4'd4};
        vecs[8]  = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 4'd5};
        vecs[9]  = '{1'b1, 8'h33, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 4'd6};
        vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd7};

        // Reset held three cycles.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_out_parity", 32'(out_parity), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_xfer_count", 32'(xfer_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        chk("rel_out_valid", 32'(out_valid), 32'd0);
        chk("rel_xfer_count", 32'(xfer_count), 32'd0);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].eir));
            chk($sformatf("vec%0d_xfer_count", i), 32'(xfer_count), 32'(vecs[i].ec));
            if (vecs[i].ev) begin
                chk($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].ed));
                chk($sformatf("vec%0d_out_zero", i), 32'(out_zero), 32'(vecs[i].ez));
                chk($sformatf("vec%0d_out_parity", i), 32'(out_parity), 32'(vecs[i].ep));
            end
        end

        // Counter wrap at 4 bits over 17 transfers.
        do_reset(1);
        for (int i = 0; i < 18; i++) begin
            step(i < 17, W'(i + 3), 1'b1);
            if (takes == 15 && i == 15) chk("wrap_15", 32'(xfer_count), 32'd15);
            if (takes == 16 && i == 16) chk("wrap_16", 32'(xfer_count), 32'd0);
            if (takes == 17 && i == 17) chk("wrap_17", 32'(xfer_count), 32'd1);
        end
        chk("wrap_total_takes", 32'(takes), 32'd17);

        // Reset mid-operation with both entries full.
        do_reset(1);
        step(1'b1, 8'hAA, 1'b0);
        step(1'b1, 8'hBB, 1'b0);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hDD;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_xfer_count", 32'(xfer_count), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        mq.delete();
        mcount = '0;
        takes  = 0;
        #1;
        chk("midrst_rel_in_ready", 32'(in_ready), 32'd1);
        step(1'b1, 8'hCC, 1'b0);
        chk("midrst_first_out", 32'(out_data), 32'hCC);
        step(1'b0, 8'h00, 1'b1);
        chk("midrst_single_take", 32'(xfer_count), 32'd1);
        chk("midrst_drained", 32'(out_valid), 32'd0);

        // Randomized traffic against the FIFO scoreboard.
        do_reset(1);
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 3) != 0), W'($urandom), ($urandom_range(0, 2) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
